// File: rtl/ysyx_24090012_pkg.sv
// Shared RV32E decode constants and LSU state/size encodings.
package ysyx_24090012_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_OUT  = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  // Any funct3 that is not a recognised byte/half encoding is a word access.
  function automatic acc_size_e access_size(input logic is_store, input logic [2:0] funct3);
    acc_size_e sz;
    sz = SZ_WORD;
    if (is_store) begin
      if (funct3 == F3_SB) sz = SZ_BYTE;
      else if (funct3 == F3_SH) sz = SZ_HALF;
    end else begin
      if (funct3 == F3_LB || funct3 == F3_LBU) sz = SZ_BYTE;
      else if (funct3 == F3_LH || funct3 == F3_LHU) sz = SZ_HALF;
    end
    return sz;
  endfunction

endpackage

// File: rtl/ysyx_24090012_lsu_if.sv
// EXU -> LSU -> WBU and LSU <-> data-memory handshake bundle; slave is the LSU view.
interface ysyx_24090012_lsu_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  exu_valid;
  logic                  exu_ready;
  logic [DATA_WIDTH-1:0] exu_result;
  logic [DATA_WIDTH-1:0] exu_store_data;
  logic [31:0]           exu_inst;
  logic [31:0]           exu_next_pc;
  logic [63:0]           exu_num;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_req_wen;
  logic [DATA_WIDTH-1:0] mem_req_wdata;
  logic [3:0]            mem_req_wstrb;
  logic                  mem_resp_valid;
  logic                  mem_resp_ready;
  logic [DATA_WIDTH-1:0] mem_resp_rdata;
  logic                  mem_resp_err;

  logic                  wbu_valid;
  logic                  wbu_ready;
  logic [DATA_WIDTH-1:0] wbu_wdata;
  logic [31:0]           wbu_inst;
  logic [31:0]           wbu_next_pc;
  logic [63:0]           wbu_num;
  logic [ADDR_WIDTH-1:0] wbu_sim_addr;
  logic                  lsu_fault;

  modport slave (
    input  exu_valid, exu_result, exu_store_data, exu_inst, exu_next_pc, exu_num,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err, wbu_ready,
    output exu_ready, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
    output mem_resp_ready, wbu_valid, wbu_wdata, wbu_inst, wbu_next_pc, wbu_num,
    output wbu_sim_addr, lsu_fault
  );

  modport master (
    output exu_valid, exu_result, exu_store_data, exu_inst, exu_next_pc, exu_num,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err, wbu_ready,
    input  exu_ready, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
    input  mem_resp_ready, wbu_valid, wbu_wdata, wbu_inst, wbu_next_pc, wbu_num,
    input  wbu_sim_addr, lsu_fault
  );
endinterface

// File: rtl/ysyx_24090012_lsu_align.sv
// Combinational lane logic: store strobes/replicated data, load extract/extend, misalign detect.
module ysyx_24090012_lsu_align
  import ysyx_24090012_pkg::*;
(
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o
);
  acc_size_e   size;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign size      = access_size(is_store_i, funct3_i);
  assign byte_lane = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  // funct3[2] marks the unsigned load variants.
  always_comb begin
    wstrb_o      = 4'b1111;
    wdata_o      = store_data_i;
    load_data_o  = rdata_i;
    misaligned_o = (addr_lo_i != 2'b00);
    case (size)
      SZ_BYTE: begin
        wstrb_o      = 4'b0001 << addr_lo_i;
        wdata_o      = {4{store_data_i[7:0]}};
        load_data_o  = funct3_i[2] ? {24'd0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
        misaligned_o = 1'b0;
      end
      SZ_HALF: begin
        wstrb_o      = 4'b0011 << addr_lo_i;
        wdata_o      = {2{store_data_i[15:0]}};
        load_data_o  = funct3_i[2] ? {16'd0, half_lane} : {{16{half_lane[15]}}, half_lane};
        misaligned_o = addr_lo_i[0];
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/ysyx_24090012_lsu.sv
// Load/store stage: one instruction in flight, at most one memory transaction, results to WBU.
// Non-memory ops reach WBU one cycle after accept; every handshake holds its outputs until ready.
module ysyx_24090012_lsu
  import ysyx_24090012_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                clock,
  input  logic                reset,
  ysyx_24090012_lsu_if.slave  lsu_bus
);
  lsu_state_e            state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] sim_addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] req_wdata_q;
  logic [3:0]            req_wstrb_q;
  logic                  req_wen_q;
  logic [31:0]           inst_q;
  logic [31:0]           next_pc_q;
  logic [63:0]           num_q;
  logic                  fault_q;

  logic        in_load, in_store, in_mem, in_idle;
  logic        al_is_store, al_misaligned;
  logic [2:0]  al_funct3;
  logic [1:0]  al_addr_lo;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata, al_load_data;

  assign in_idle  = (state_q == S_IDLE);
  assign in_load  = (lsu_bus.exu_inst[6:0] == OPC_LOAD);
  assign in_store = (lsu_bus.exu_inst[6:0] == OPC_STORE);
  assign in_mem   = in_load | in_store;

  // The aligner sees the incoming instruction while idle and the captured one afterwards.
  assign al_is_store = in_idle ? in_store : req_wen_q;
  assign al_funct3   = in_idle ? lsu_bus.exu_inst[14:12] : inst_q[14:12];
  assign al_addr_lo  = in_idle ? lsu_bus.exu_result[1:0] : addr_q[1:0];

  ysyx_24090012_lsu_align u_align (
    .is_store_i   (al_is_store),
    .funct3_i     (al_funct3),
    .addr_lo_i    (al_addr_lo),
    .store_data_i (lsu_bus.exu_store_data),
    .rdata_i      (lsu_bus.mem_resp_rdata),
    .wstrb_o      (al_wstrb),
    .wdata_o      (al_wdata),
    .load_data_o  (al_load_data),
    .misaligned_o (al_misaligned)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      sim_addr_q  <= '0;
      wdata_q     <= '0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
      req_wen_q   <= 1'b0;
      inst_q      <= '0;
      next_pc_q   <= '0;
      num_q       <= '0;
      fault_q     <= 1'b0;
    end else begin
      fault_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (lsu_bus.exu_valid) begin
            inst_q      <= lsu_bus.exu_inst;
            next_pc_q   <= lsu_bus.exu_next_pc;
            num_q       <= lsu_bus.exu_num;
            addr_q      <= lsu_bus.exu_result[ADDR_WIDTH-1:0];
            sim_addr_q  <= in_mem ? lsu_bus.exu_result[ADDR_WIDTH-1:0] : '0;
            req_wen_q   <= in_store;
            req_wstrb_q <= in_store ? al_wstrb : 4'b0000;
            req_wdata_q <= in_store ? al_wdata : '0;
            if (!in_mem) begin
              wdata_q <= lsu_bus.exu_result;
              state_q <= S_OUT;
            end else if (al_misaligned) begin
              wdata_q <= '0;
              fault_q <= 1'b1;
              state_q <= S_OUT;
            end else begin
              state_q <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (lsu_bus.mem_req_ready) state_q <= S_RESP;
        end
        S_RESP: begin
          if (lsu_bus.mem_resp_valid) begin
            if (lsu_bus.mem_resp_err) begin
              wdata_q <= '0;
              fault_q <= 1'b1;
            end else begin
              wdata_q <= req_wen_q ? '0 : al_load_data;
            end
            state_q <= S_OUT;
          end
        end
        S_OUT: begin
          if (lsu_bus.wbu_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign lsu_bus.exu_ready      = in_idle;
  assign lsu_bus.mem_req_valid  = (state_q == S_REQ);
  assign lsu_bus.mem_resp_ready = (state_q == S_RESP);
  assign lsu_bus.wbu_valid      = (state_q == S_OUT);
  assign lsu_bus.mem_req_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign lsu_bus.mem_req_wen    = req_wen_q;
  assign lsu_bus.mem_req_wdata  = req_wdata_q;
  assign lsu_bus.mem_req_wstrb  = req_wstrb_q;
  assign lsu_bus.wbu_wdata      = wdata_q;
  assign lsu_bus.wbu_inst       = inst_q;
  assign lsu_bus.wbu_next_pc    = next_pc_q;
  assign lsu_bus.wbu_num        = num_q;
  assign lsu_bus.wbu_sim_addr   = sim_addr_q;
  assign lsu_bus.lsu_fault      = fault_q;
endmodule

// File: tb/tb_ysyx_24090012_lsu.sv
// Directed vector bench for the LSU: table of single-instruction cases plus backpressure and reset sequences.
module tb_ysyx_24090012_lsu;
  import ysyx_24090012_pkg::*;

  localparam logic [6:0] OPC_OP_IMM_TB = 7'b0010011;
  localparam logic [6:0] OPC_OP_TB     = 7'b0110011;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] result;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic        err;
    logic        mem;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] out;
    logic [31:0] sim;
    logic        fault;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs[16];

  always #5 clk = ~clk;

  ysyx_24090012_lsu_if bus ();

  ysyx_24090012_lsu dut (
    .clock   (clk),
    .reset   (rst),
    .lsu_bus (bus)
  );

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] opc);
    return {17'd0, f3, 5'd1, opc};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [31:0] inst, input logic [31:0] res, input logic [31:0] sd, input int idx);
    bus.exu_valid      = 1'b1;
    bus.exu_inst       = inst;
    bus.exu_result     = res;
    bus.exu_store_data = sd;
    bus.exu_next_pc    = 32'h8000_0000 + 32'(idx * 4);
    bus.exu_num        = 64'h1_0000_0000 + 64'(idx);
    @(negedge clk);
    bus.exu_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    chk($sformatf("v%0d_idle_exu_ready", idx), 64'(bus.exu_ready), 64'd1);
    issue(v.inst, v.result, v.sdata, idx);
    if (v.mem) begin
      chk($sformatf("v%0d_req_valid", idx), 64'(bus.mem_req_valid), 64'd1);
      chk($sformatf("v%0d_req_addr", idx), 64'(bus.mem_req_addr), 64'(v.addr));
      chk($sformatf("v%0d_req_wen", idx), 64'(bus.mem_req_wen), 64'(v.wen));
      chk($sformatf("v%0d_req_wstrb", idx), 64'(bus.mem_req_wstrb), 64'(v.wstrb));
      if (v.wen) chk($sformatf("v%0d_req_wdata", idx), 64'(bus.mem_req_wdata), 64'(v.wdata));
      chk($sformatf("v%0d_busy_exu_ready", idx), 64'(bus.exu_ready), 64'd0);
      bus.mem_req_ready = 1'b1;
      @(negedge clk);
      bus.mem_req_ready = 1'b0;
      chk($sformatf("v%0d_resp_ready", idx), 64'(bus.mem_resp_ready), 64'd1);
      chk($sformatf("v%0d_req_dropped", idx), 64'(bus.mem_req_valid), 64'd0);
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_rdata = v.rdata;
      bus.mem_resp_err   = v.err;
      @(negedge clk);
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_err   = 1'b0;
    end else begin
      chk($sformatf("v%0d_no_req", idx), 64'(bus.mem_req_valid), 64'd0);
    end
    chk($sformatf("v%0d_wbu_valid", idx), 64'(bus.wbu_valid), 64'd1);
    chk($sformatf("v%0d_wbu_wdata", idx), 64'(bus.wbu_wdata), 64'(v.out));
    chk($sformatf("v%0d_sim_addr", idx), 64'(bus.wbu_sim_addr), 64'(v.sim));
    chk($sformatf("v%0d_fault", idx), 64'(bus.lsu_fault), 64'(v.fault));
    chk($sformatf("v%0d_wbu_inst", idx), 64'(bus.wbu_inst), 64'(v.inst));
    chk($sformatf("v%0d_wbu_pc", idx), 64'(bus.wbu_next_pc), 64'(32'h8000_0000 + 32'(idx * 4)));
    chk($sformatf("v%0d_wbu_num", idx), bus.wbu_num, 64'h1_0000_0000 + 64'(idx));
    chk($sformatf("v%0d_out_exu_ready", idx), 64'(bus.exu_ready), 64'd0);
    bus.wbu_ready = 1'b1;
    @(negedge clk);
    bus.wbu_ready = 1'b0;
    chk($sformatf("v%0d_done_wbu_valid", idx), 64'(bus.wbu_valid), 64'd0);
    chk($sformatf("v%0d_done_exu_ready", idx), 64'(bus.exu_ready), 64'd1);
    chk($sformatf("v%0d_fault_pulse", idx), 64'(bus.lsu_fault), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    bus.exu_valid = 1'b0; bus.exu_result = '0; bus.exu_store_data = '0;
    bus.exu_inst = '0; bus.exu_next_pc = '0; bus.exu_num = '0;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = '0; bus.mem_resp_err = 1'b0; bus.wbu_ready = 1'b0;

    //          inst                     result        sdata         rdata         err   mem   addr          wen   wdata         wstrb    out           sim           fault
    vecs[0]  = '{mk(3'b000, OPC_OP_IMM_TB), 32'h00000005, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        4'b0000, 32'h00000005, 32'h0,        1'b0};
    vecs[1]  = '{mk(F3_LB,  OPC_LOAD),   32'h80000003, 32'h0,        32'h80FF1234, 1'b0, 1'b1, 32'h80000000, 1'b0, 32'h0,        4'b0000, 32'hFFFFFF80, 32'h80000003, 1'b0};
    vecs[2]  = '{mk(F3_LBU, OPC_LOAD),   32'h80000003, 32'h0,        32'h80FF1234, 1'b0, 1'b1, 32'h80000000, 1'b0, 32'h0,        4'b0000, 32'h00000080, 32'h80000003, 1'b0};
    vecs[3]  = '{mk(F3_SH,  OPC_STORE),  32'h80000002, 32'h0000BEEF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000, 1'b1, 32'hBEEFBEEF, 4'b1100, 32'h0,        32'h80000002, 1'b0};
    vecs[4]  = '{mk(F3_LW,  OPC_LOAD),   32'h80000001, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        4'b0000, 32'h0,        32'h80000001, 1'b1};
    vecs[5]  = '{mk(F3_LH,  OPC_LOAD),   32'h80000002, 32'h0,        32'h80FF1234, 1'b0, 1'b1, 32'h80000000, 1'b0, 32'h0,        4'b0000, 32'hFFFF80FF, 32'h80000002, 1'b0};
    vecs[6]  = '{mk(F3_LHU, OPC_LOAD),   32'h00000010, 32'h0,        32'h1234ABCD, 1'b0, 1'b1, 32'h00000010, 1'b0, 32'h0,        4'b0000, 32'h0000ABCD, 32'h00000010, 1'b0};
    vecs[7]  = '{mk(F3_LW,  OPC_LOAD),   32'h00000100, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1, 32'h00000100, 1'b0, 32'h0,        4'b0000, 32'hDEADBEEF, 32'h00000100, 1'b0};
    vecs[8]  = '{mk(F3_SB,  OPC_STORE),  32'h00000201, 32'h123456A5, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h00000200, 1'b1, 32'hA5A5A5A5, 4'b0010, 32'h0,        32'h00000201, 1'b0};
    vecs[9]  = '{mk(F3_SW,  OPC_STORE),  32'h00000300, 32'hCAFEF00D, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h00000300, 1'b1, 32'hCAFEF00D, 4'b1111, 32'h0,        32'h00000300, 1'b0};
    vecs[10] = '{mk(F3_SH,  OPC_STORE),  32'h00000403, 32'h0000FFFF, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        4'b0000, 32'h0,        32'h00000403, 1'b1};
    vecs[11] = '{mk(F3_LW,  OPC_LOAD),   32'h00000500, 32'h0,        32'h12345678, 1'b1, 1'b1, 32'h00000500, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h00000500, 1'b1};
    vecs[12] = '{mk(3'b011, OPC_LOAD),   32'h00000602, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        4'b0000, 32'h0,        32'h00000602, 1'b1};
    vecs[13] = '{mk(F3_LB,  OPC_LOAD),   32'h00000701, 32'h0,        32'h00007F00, 1'b0, 1'b1, 32'h00000700, 1'b0, 32'h0,        4'b0000, 32'h0000007F, 32'h00000701, 1'b0};
    vecs[14] = '{mk(3'b000, OPC_OP_TB),  32'hFFFFFFFF, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        4'b0000, 32'hFFFFFFFF, 32'h0,        1'b0};
    vecs[15] = '{mk(3'b011, OPC_STORE),  32'h00000904, 32'h0BADF00D, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h00000904, 1'b1, 32'h0BADF00D, 4'b1111, 32'h0,        32'h00000904, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_exu_ready", 64'(bus.exu_ready), 64'd1);
    chk("rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
    chk("rst_resp_ready", 64'(bus.mem_resp_ready), 64'd0);
    chk("rst_wbu_valid", 64'(bus.wbu_valid), 64'd0);
    chk("rst_fault", 64'(bus.lsu_fault), 64'd0);
    chk("rst_wbu_wdata", 64'(bus.wbu_wdata), 64'd0);
    chk("rst_sim_addr", 64'(bus.wbu_sim_addr), 64'd0);
    chk("rst_wstrb", 64'(bus.mem_req_wstrb), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // Memory and writeback backpressure on a word store.
    @(negedge clk);
    issue(mk(F3_SW, OPC_STORE), 32'h00000700, 32'h11223344, 20);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h55555555;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp_req_valid_c%0d", c), 64'(bus.mem_req_valid), 64'd1);
      chk($sformatf("bp_req_addr_c%0d", c), 64'(bus.mem_req_addr), 64'h700);
      chk($sformatf("bp_req_wdata_c%0d", c), 64'(bus.mem_req_wdata), 64'h11223344);
      chk($sformatf("bp_req_wstrb_c%0d", c), 64'(bus.mem_req_wstrb), 64'hF);
      chk($sformatf("bp_req_wen_c%0d", c), 64'(bus.mem_req_wen), 64'd1);
      chk($sformatf("bp_req_exu_ready_c%0d", c), 64'(bus.exu_ready), 64'd0);
      @(negedge clk);
    end
    bus.mem_resp_valid = 1'b0;
    bus.mem_req_ready  = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    chk("bp_resp_ready", 64'(bus.mem_resp_ready), 64'd1);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h0;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("bp_wbu_valid_c%0d", c), 64'(bus.wbu_valid), 64'd1);
      chk($sformatf("bp_wbu_wdata_c%0d", c), 64'(bus.wbu_wdata), 64'd0);
      chk($sformatf("bp_wbu_sim_c%0d", c), 64'(bus.wbu_sim_addr), 64'h700);
      chk($sformatf("bp_wbu_num_c%0d", c), bus.wbu_num, 64'h1_0000_0014);
      chk($sformatf("bp_wbu_exu_ready_c%0d", c), 64'(bus.exu_ready), 64'd0);
      @(negedge clk);
    end
    chk("bp_wbu_still_valid", 64'(bus.wbu_valid), 64'd1);
    bus.wbu_ready = 1'b1;
    @(negedge clk);
    bus.wbu_ready = 1'b0;
    chk("bp_released", 64'(bus.wbu_valid), 64'd0);

    // Reset while waiting for a load response; the late response must be ignored.
    issue(mk(F3_LW, OPC_LOAD), 32'h00000800, 32'h0, 21);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    chk("rr_in_resp", 64'(bus.mem_resp_ready), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rr_exu_ready", 64'(bus.exu_ready), 64'd1);
    chk("rr_wbu_valid", 64'(bus.wbu_valid), 64'd0);
    chk("rr_resp_ready", 64'(bus.mem_resp_ready), 64'd0);
    chk("rr_req_valid", 64'(bus.mem_req_valid), 64'd0);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'hAAAAAAAA;
    repeat (2) @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    chk("rr_late_resp_wbu_valid", 64'(bus.wbu_valid), 64'd0);
    chk("rr_late_resp_exu_ready", 64'(bus.exu_ready), 64'd1);
    chk("rr_late_resp_fault", 64'(bus.lsu_fault), 64'd0);
    run_vec(vecs[7], 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
